// File: rtl/gups_pkg.sv
// gups_pkg: shared definitions for the GUPS engine.
//   - state_e       : engine FSM state encoding
//   - LfsrMask      : Galois feedback mask (x^16+x^14+x^13+x^11+1)
//   - ZeroSeedSub   : value loaded in place of an all-zero seed lane
//   - lfsr_step()   : one Galois shift of a 16-bit lane
package gups_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StRd,
    StMod,
    StWr,
    StDone
  } state_e;

  localparam logic [15:0] LfsrMask    = 16'hB400;
  localparam logic [15:0] ZeroSeedSub = 16'h0001;

  // Right-shifting Galois LFSR: the bit shifted out selects the feedback mask.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LfsrMask : 16'h0000);
  endfunction

endpackage

// File: rtl/gups_lfsr16.sv
// gups_lfsr16: one 16-bit Galois LFSR lane of the GUPS random address.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset (lane returns to 16'h0001)
//   load  - load from seed (a zero seed loads 16'h0001 so the lane never locks up)
//   step  - advance the lane one Galois step (load has priority)
//   seed  - 16-bit seed value
//   value - current lane value
module gups_lfsr16
  import gups_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 16'h0000) ? ZeroSeedSub : seed;
    end else if (step) begin
      value_d = lfsr_step(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= ZeroSeedSub;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/gups_engine.sv
// gups_engine: random-access read-modify-write (GUPS) update engine.
// Each update: GEN steps the LFSR lanes and forms the address, RD reads the
// word, MOD computes the new value, WR writes it back.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   start          - launch a run (ignored while busy)
//   num_updates    - updates per run
//   seed           - LANES x 16-bit LFSR seeds, lane i at [16i+15:16i]
//   range          - address mask, sampled per update
//   mode           - 0: increment, 1: XOR with replicated random word (per update)
//   addr/dout/din  - memory address, write data, read data
//   req/wr/rdy     - memory request, write flag, completion strobe
//   busy/done      - run in progress / run finished
//   upd_count      - completed updates
//   stall_count    - cycles with req=1 and rdy=0 (saturating); only counts
//                    when GUPS_STALL_CNT_EN is defined, otherwise tied to 0
module gups_engine
  import gups_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_updates,
  input  logic [LANES*16-1:0]  seed,
  input  logic [ADDR_W-1:0]    range,
  input  logic                 mode,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    dout,
  input  logic [DATA_W-1:0]    din,
  output logic                 req,
  output logic                 wr,
  input  logic                 rdy,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     upd_count,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int unsigned CatW = LANES * 16;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  upd_q, upd_d;

  logic              lane_load, lane_step, launch;
  logic [CatW-1:0]   lane_cat, lane_next;
  logic [ADDR_W-1:0] addr_raw;
  logic [DATA_W-1:0] rep_word;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gups_lfsr16 u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (lane_load),
      .step  (lane_step),
      .seed  (seed[16*g +: 16]),
      .value (lane_cat[16*g +: 16])
    );
  end

  // The address is registered in GEN, so it is formed from the lanes' next values.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_next[16*i +: 16] = lfsr_step(lane_cat[16*i +: 16]);
    end
  end

  // Zero-extend or truncate the lane concatenation to ADDR_W.
  always_comb begin
    addr_raw = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (i < CatW) addr_raw[i] = lane_next[i % CatW];
    end
  end

  // Replicate the current lane concatenation across DATA_W for XOR mode.
  always_comb begin
    rep_word = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      rep_word[i] = lane_cat[i % CatW];
    end
  end

  assign launch = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    din_d     = din_q;
    mode_d    = mode_q;
    upd_d     = upd_q;
    lane_load = 1'b0;
    lane_step = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (launch) begin
          lane_load = 1'b1;
          upd_d     = '0;
          state_d   = StGen;
        end
      end
      StGen: begin
        if (upd_q == num_updates) begin
          state_d = StDone;
        end else begin
          lane_step = 1'b1;
          addr_d    = addr_raw & range;
          mode_d    = mode;
          state_d   = StRd;
        end
      end
      StRd: begin
        if (rdy) begin
          din_d   = din;
          state_d = StMod;
        end
      end
      StMod: begin
        dout_d  = mode_q ? (din_q ^ rep_word) : (din_q + DATA_W'(1));
        state_d = StWr;
      end
      StWr: begin
        if (rdy) begin
          upd_d   = upd_q + CNT_W'(1);
          state_d = StGen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dout_q  <= '0;
      din_q   <= '0;
      mode_q  <= 1'b0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
      mode_q  <= mode_d;
      upd_q   <= upd_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign req       = (state_q == StRd) || (state_q == StWr);
  assign wr        = (state_q == StWr);
  assign busy      = (state_q == StGen) || (state_q == StRd) ||
                     (state_q == StMod) || (state_q == StWr);
  assign done      = (state_q == StDone);
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign upd_count = upd_q;

`ifdef GUPS_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (launch) begin
      stall_d = '0;
    end else if (req && !rdy && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gups_engine.sv
// tb_gups_engine: randomized self-checking bench for gups_engine.
// A memory responder answers requests after a programmable wait and logs every
// completed transaction; each test compares the log against an address/word
// stream produced by a reference LFSR model. Stall expectations follow
// GUPS_STALL_CNT_EN.
module tb_gups_engine;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int LANES  = 4;
  localparam int CNT_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CNT_W-1:0]    num_updates;
  logic [LANES*16-1:0] seed;
  logic [ADDR_W-1:0]   range;
  logic                mode;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   dout;
  logic [DATA_W-1:0]   din;
  logic                req;
  logic                wr;
  logic                rdy;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    upd_count;
  logic [CNT_W-1:0]    stall_count;

  gups_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_updates (num_updates),
    .seed        (seed),
    .range       (range),
    .mode        (mode),
    .addr        (addr),
    .dout        (dout),
    .din         (din),
    .req         (req),
    .wr          (wr),
    .rdy         (rdy),
    .busy        (busy),
    .done        (done),
    .upd_count   (upd_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder state and transaction log.
  int          rd_wait = 0;
  int          wr_wait = 0;
  bit          force_ones = 1'b0;
  int          wait_cnt = 0;
  int          req_cycles = 0;
  bit          log_wr[$];
  logic [63:0] log_addr[$];
  logic [63:0] log_data[$];
  logic [63:0] mem[logic [63:0]];
  logic [63:0] ref_mem[logic [63:0]];

  // Reference model output: expected address and raw lane word per update.
  logic [63:0] exp_addr[$];
  logic [63:0] exp_word[$];

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst && req) req_cycles++;
    if (!rst) begin
      rdy      = 1'b0;
      wait_cnt = 0;
    end else if (rdy) begin
      rdy      = 1'b0;
      wait_cnt = 0;
      din      = rand64();
    end else if (req) begin
      if (wait_cnt >= (wr ? wr_wait : rd_wait)) begin
        rdy = 1'b1;
        if (wr) begin
          mem[addr] = dout;
          log_wr.push_back(1'b1);
          log_addr.push_back(addr);
          log_data.push_back(dout);
        end else begin
          if (!mem.exists(addr)) mem[addr] = rand64();
          din = force_ones ? 64'hFFFF_FFFF_FFFF_FFFF : mem[addr];
          log_wr.push_back(1'b0);
          log_addr.push_back(addr);
          log_data.push_back(din);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Reference: LANES independent maximal-length 16-bit Galois sequences.
  task automatic model_gen(input logic [63:0] sd, input int n, input logic [63:0] rng);
    int unsigned ln[4];
    logic [63:0] w;
    exp_addr.delete();
    exp_word.delete();
    for (int i = 0; i < 4; i++) begin
      ln[i] = 32'(sd[16*i +: 16]);
      if (ln[i] == 0) ln[i] = 1;
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        ln[i] = (ln[i] % 2 == 1) ? ((ln[i] / 2) ^ 32'hB400) : (ln[i] / 2);
      end
      w = {ln[3][15:0], ln[2][15:0], ln[1][15:0], ln[0][15:0]};
      exp_word.push_back(w);
      exp_addr.push_back(w & rng);
    end
  endtask

  task automatic clear_log();
    log_wr.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic start_run(input logic [63:0] sd, input int n, input bit md,
                           input logic [63:0] rng);
    @(posedge clk);
    #1;
    seed        = sd;
    num_updates = n;
    mode        = md;
    range       = rng;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", req); end
    n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL rst_wr got %b want 0", wr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (addr !== 64'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", addr); end
    n_cmp++; if (dout !== 64'h0) begin n_bad++; $display("FAIL rst_dout got %h want 0", dout); end
    n_cmp++;
    if (upd_count !== 32'h0) begin n_bad++; $display("FAIL rst_upd got %0d want 0", upd_count); end
    n_cmp++;
    if (stall_count !== 32'h0) begin
      n_bad++; $display("FAIL rst_stall got %0d want 0", stall_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || req !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_rst got busy=%b done=%b req=%b want 0/0/0", busy, done, req);
    end
  endtask

  task automatic test_increment();
    logic [63:0] sd, expw;
    bit ok;
    int n = 1000;
    mem.delete();
    for (int a = 0; a < 8192; a++) mem[64'(a)] = rand64();
    ref_mem = mem;
    clear_log();
    rd_wait = 2;
    wr_wait = 5;
    force_ones = 1'b0;
    sd = rand64();
    model_gen(sd, n, 64'h1FFF);
    start_run(sd, n, 1'b0, 64'h1FFF);
    wait_done(20000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL inc_timeout got done=%b want 1", done); end
    n_cmp++;
    if (log_wr.size() != 2 * n) begin
      n_bad++; $display("FAIL inc_txn_count got %0d want %0d", log_wr.size(), 2 * n);
    end
    for (int k = 0; k < n && 2 * k + 1 < log_wr.size(); k++) begin
      n_cmp++;
      if (log_wr[2*k] !== 1'b0 || log_addr[2*k] !== exp_addr[k]) begin
        n_bad++;
        $display("FAIL inc_rd_addr[%0d] got wr=%b %h want wr=0 %h", k, log_wr[2*k],
                 log_addr[2*k], exp_addr[k]);
      end
      n_cmp++;
      if (log_wr[2*k+1] !== 1'b1 || log_addr[2*k+1] !== exp_addr[k]) begin
        n_bad++;
        $display("FAIL inc_wr_addr[%0d] got wr=%b %h want wr=1 %h", k, log_wr[2*k+1],
                 log_addr[2*k+1], exp_addr[k]);
      end
      expw = ref_mem[exp_addr[k]] + 64'd1;
      ref_mem[exp_addr[k]] = expw;
      n_cmp++;
      if (log_data[2*k+1] !== expw) begin
        n_bad++; $display("FAIL inc_wr_data[%0d] got %h want %h", k, log_data[2*k+1], expw);
      end
    end
    n_cmp++;
    if (upd_count !== 32'(n)) begin n_bad++; $display("FAIL inc_upd got %0d want %0d", upd_count, n); end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL inc_flags got done=%b busy=%b want 1/0", done, busy);
    end
    n_cmp++;
`ifdef GUPS_STALL_CNT_EN
    if (stall_count !== 32'd7000) begin
      n_bad++; $display("FAIL inc_stall got %0d want 7000", stall_count);
    end
`else
    if (stall_count !== 32'd0) begin
      n_bad++; $display("FAIL inc_stall got %0d want 0", stall_count);
    end
`endif
  endtask

  task automatic test_zero_updates();
    req_cycles = 0;
    start_run(rand64(), 0, 1'b0, 64'hFFFF);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL zero_cycle1 got busy=%b done=%b want 1/0", busy, done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_cycle2 got done=%b busy=%b want 1/0", done, busy);
    end
    repeat (5) @(posedge clk);
    #2;
    n_cmp++; if (req_cycles != 0) begin n_bad++; $display("FAIL zero_req got %0d want 0", req_cycles); end
    n_cmp++;
    if (upd_count !== 32'd0 || done !== 1'b1) begin
      n_bad++; $display("FAIL zero_hold got upd=%0d done=%b want 0/1", upd_count, done);
    end
  endtask

  task automatic test_zero_seed();
    logic [63:0] sd, expw, rng;
    logic [15:0] first_lane0;
    bit ok, md;
    int n = 20;
    clear_log();
    rd_wait = $urandom_range(0, 3);
    wr_wait = $urandom_range(0, 3);
    md = 1'($urandom_range(0, 1));
    sd = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)),
          16'($urandom_range(1, 65535)), 16'h0000};
    rng = 64'hFFFF_FFFF_FFFF_FFFF;
    model_gen(sd, n, rng);
    start_run(sd, n, md, rng);
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL zseed_timeout got done=%b want 1", done); end
    n_cmp++;
    if (log_wr.size() != 2 * n) begin
      n_bad++; $display("FAIL zseed_txn_count got %0d want %0d", log_wr.size(), 2 * n);
    end
    if (log_addr.size() > 0) begin
      first_lane0 = log_addr[0][15:0];
      // Seed 0001 stepped once: the shifted-out 1 applies the mask to zero.
      n_cmp++;
      if (first_lane0 !== 16'hB400) begin
        n_bad++; $display("FAIL zseed_lane0_first got %h want b400", first_lane0);
      end
    end
    for (int k = 0; k < n && 2 * k + 1 < log_wr.size(); k++) begin
      n_cmp++;
      if (log_addr[2*k] !== exp_addr[k] || log_addr[2*k+1] !== exp_addr[k]) begin
        n_bad++;
        $display("FAIL zseed_addr[%0d] got %h/%h want %h", k, log_addr[2*k], log_addr[2*k+1],
                 exp_addr[k]);
      end
      expw = md ? (log_data[2*k] ^ exp_word[k]) : (log_data[2*k] + 64'd1);
      n_cmp++;
      if (log_data[2*k+1] !== expw) begin
        n_bad++; $display("FAIL zseed_data[%0d] got %h want %h", k, log_data[2*k+1], expw);
      end
    end
  endtask

  task automatic test_xor_ones();
    logic [63:0] sd, rng;
    bit ok;
    int n = 16;
    clear_log();
    rd_wait = 1;
    wr_wait = 0;
    force_ones = 1'b1;
    sd = rand64();
    rng = rand64();
    model_gen(sd, n, rng);
    start_run(sd, n, 1'b1, rng);
    wait_done(1000, ok);
    force_ones = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL xor_timeout got done=%b want 1", done); end
    for (int k = 0; k < n && 2 * k + 1 < log_wr.size(); k++) begin
      n_cmp++;
      if (log_addr[2*k+1] !== exp_addr[k]) begin
        n_bad++; $display("FAIL xor_addr[%0d] got %h want %h", k, log_addr[2*k+1], exp_addr[k]);
      end
      n_cmp++;
      if (log_data[2*k+1] !== ~exp_word[k]) begin
        n_bad++; $display("FAIL xor_data[%0d] got %h want %h", k, log_data[2*k+1], ~exp_word[k]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_log();
    rd_wait = 3;
    wr_wait = 3;
    start_run(rand64(), 10, 1'($urandom_range(0, 1)), 64'hFFF);
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout got done=%b want 1", done); end
    n_cmp++;
    if (upd_count !== 32'd10) begin n_bad++; $display("FAIL stall_upd got %0d want 10", upd_count); end
    n_cmp++;
`ifdef GUPS_STALL_CNT_EN
    if (stall_count !== 32'd60) begin
      n_bad++; $display("FAIL stall_count got %0d want 60", stall_count);
    end
`else
    if (stall_count !== 32'd0) begin
      n_bad++; $display("FAIL stall_count got %0d want 0", stall_count);
    end
`endif
  endtask

  task automatic test_reset_in_wr();
    bit found = 1'b0;
    int nw;
    clear_log();
    rd_wait = 0;
    wr_wait = 20;
    start_run(rand64(), 5, 1'b0, 64'hFFFF);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #2;
      if (req && wr) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rwr_reach got found=0 want 1"); end
    #1;
    nw = 0;
    foreach (log_wr[i]) if (log_wr[i]) nw++;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req !== 1'b0 || wr !== 1'b0) begin
      n_bad++; $display("FAIL rwr_req got req=%b wr=%b want 0/0", req, wr);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rwr_busy got %b want 0", busy); end
    n_cmp++;
    if (addr !== 64'h0 || upd_count !== 32'h0) begin
      n_bad++; $display("FAIL rwr_regs got addr=%h upd=%0d want 0/0", addr, upd_count);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req_cycles = 0;
    repeat (30) @(posedge clk);
    #2;
    begin
      int nw2 = 0;
      foreach (log_wr[i]) if (log_wr[i]) nw2++;
      n_cmp++;
      if (nw2 != nw) begin n_bad++; $display("FAIL rwr_writes got %0d want %0d", nw2, nw); end
    end
    n_cmp++;
    if (req_cycles != 0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rwr_idle got req_cycles=%0d busy=%b done=%b want 0/0/0", req_cycles, busy,
               done);
    end
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    num_updates = '0;
    seed        = '0;
    range       = '0;
    mode        = 1'b0;
    din         = '0;
    rdy         = 1'b0;
    test_reset();
    test_increment();
    test_zero_updates();
    test_zero_seed();
    test_xor_ones();
    test_stall();
    test_reset_in_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
